// File: rtl/pipeline_sched.sv
// Central scheduler for the IF -> RD -> EX -> WB pipeline: stage valids, RAW
// hazard stalls, branch flush, STOP drain/halt and a saturating stall counter.
module pipeline_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       ir_rd,
  input  logic [7:0]       ir_ex,
  input  logic [7:0]       ir_wb,
  input  logic             br_cond,
  output logic             pc_inc,
  output logic             pc_br,
  output logic             ir1_load,
  output logic             ir2_load,
  output logic             ir3_load,
  output logic             en_rd,
  output logic             en_ex,
  output logic             en_wb,
  output logic             stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h0, OP_STOP = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h4,
    OP_BZ    = 4'h5, OP_SUB  = 4'h6, OP_NAND  = 4'h8, OP_BNZ = 4'h9,
    OP_NOP   = 4'hA, OP_BPZ  = 4'hD
  } opcode_e;

  // shift (x011) and ori (x111) decode on the low three bits only
  function automatic logic is_writer(input logic [3:0] op);
    is_writer = (op[2:0] == 3'd3) || (op[2:0] == 3'd7) ||
                (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) || (op == OP_LOAD);
  endfunction

  function automatic logic reads_reg(input logic [7:0] ir, input logic [1:0] r);
    reads_reg = 1'b0;
    if (ir[2:0] == 3'd7)
      reads_reg = (r == 2'd1);
    else if (ir[2:0] == 3'd3)
      reads_reg = (ir[7:6] == r);
    else if (ir[3:0] == OP_LOAD)
      reads_reg = (ir[5:4] == r);
    else if (ir[3:0] inside {OP_ADD, OP_SUB, OP_NAND, OP_STORE})
      reads_reg = (ir[7:6] == r) || (ir[5:4] == r);
  endfunction

  logic             r_v_rd, r_v_ex, r_v_wb, r_fetch_blk, r_halted;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_dst_ex, w_dst_wb;
  logic       w_haz_ex, w_haz_wb, w_hazard, w_taken, w_stall, w_run;
  logic       w_stop_rd, w_stop_wb, w_unused;

  assign w_dst_ex  = (ir_ex[2:0] == 3'd7) ? 2'd1 : ir_ex[7:6];
  assign w_dst_wb  = (ir_wb[2:0] == 3'd7) ? 2'd1 : ir_wb[7:6];
  assign w_haz_ex  = r_v_ex & is_writer(ir_ex[3:0]) & reads_reg(ir_rd, w_dst_ex);
  assign w_haz_wb  = r_v_wb & is_writer(ir_wb[3:0]) & reads_reg(ir_rd, w_dst_wb);
  assign w_hazard  = r_v_rd & (w_haz_ex | w_haz_wb);
  assign w_taken   = r_v_ex & br_cond & (ir_ex[3:0] inside {OP_BZ, OP_BNZ, OP_BPZ});
  assign w_stall   = w_hazard & ~w_taken;
  assign w_stop_rd = r_v_rd & (ir_rd[3:0] == OP_STOP);
  assign w_stop_wb = r_v_wb & (ir_wb[3:0] == OP_STOP);
  assign w_unused  = &{1'b0, ir_ex[5:4], ir_wb[5:4]};

  // NOTE: strobes are combinational, so reset must gate them explicitly;
  // cleared state alone would still leave pc_inc/ir*_load high during reset.
  assign w_run     = ~reset & ~r_halted;
  assign pc_br     = w_run & w_taken;
  assign pc_inc    = w_run & ~w_taken & ~w_hazard & ~r_fetch_blk;
  assign ir1_load  = w_run & ~w_stall;
  assign ir2_load  = w_run & ~w_stall;
  assign ir3_load  = w_run;
  assign stall     = w_run & w_stall;
  assign en_rd     = w_run & r_v_rd;
  assign en_ex     = w_run & r_v_ex;
  assign en_wb     = w_run & r_v_wb;
  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v_rd      <= 1'b0;
      r_v_ex      <= 1'b0;
      r_v_wb      <= 1'b0;
      r_fetch_blk <= 1'b0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else if (!r_halted) begin
      if (w_stop_wb) r_halted <= 1'b1;
      if (w_taken) begin
        // the RD instruction and the fetch in flight are both wrong-path
        r_v_rd <= 1'b0;
        r_v_ex <= 1'b0;
        r_v_wb <= 1'b1;
      end else if (w_stall) begin
        r_v_ex <= 1'b0;
        r_v_wb <= r_v_ex;
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_v_rd <= ~r_fetch_blk & ~w_stop_rd;
        r_v_ex <= r_v_rd;
        r_v_wb <= r_v_ex;
        if (w_stop_rd) r_fetch_blk <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed bench for pipeline_sched: a small IR/PC datapath model feeds the
// scheduler and each scenario compares per-cycle strobes against hand tables.
module tb_pipeline_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        br_cond = 1'b0;
  logic [7:0]  ir_rd, ir_ex, ir_wb;
  logic        pc_inc, pc_br, ir1_load, ir2_load, ir3_load;
  logic        en_rd, en_ex, en_wb, stall, halted;
  logic [15:0] stall_cnt;

  logic        s_pc_inc, s_pc_br, s_ir1_load, s_ir2_load, s_ir3_load;
  logic        s_en_rd, s_en_ex, s_en_wb, s_stall, s_halted;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] imem [0:63];
  logic [5:0] pc;
  logic [9:0] obs;

  // strobe vector: pc_inc pc_br ir1 ir2 ir3 en_rd en_ex en_wb stall halted
  localparam logic [9:0] ADV0     = 10'b1011100000;
  localparam logic [9:0] ADV_R    = 10'b1011110000;
  localparam logic [9:0] ADV_RE   = 10'b1011111000;
  localparam logic [9:0] ADV_ALL  = 10'b1011111100;
  localparam logic [9:0] STALL_EX = 10'b0000111010;
  localparam logic [9:0] STALL_WB = 10'b0000110110;
  localparam logic [9:0] TAKEN    = 10'b0111111000;
  localparam logic [9:0] POST_BR  = 10'b1011100100;
  localparam logic [9:0] STOP_EX  = 10'b0011101000;
  localparam logic [9:0] STOP_WB  = 10'b0011100100;
  localparam logic [9:0] HALT     = 10'b0000000001;

  assign obs = {pc_inc, pc_br, ir1_load, ir2_load, ir3_load, en_rd, en_ex, en_wb, stall, halted};

  pipeline_sched #(.CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .ir_rd(ir_rd), .ir_ex(ir_ex), .ir_wb(ir_wb),
    .br_cond(br_cond), .pc_inc(pc_inc), .pc_br(pc_br), .ir1_load(ir1_load),
    .ir2_load(ir2_load), .ir3_load(ir3_load), .en_rd(en_rd), .en_ex(en_ex),
    .en_wb(en_wb), .stall(stall), .halted(halted), .stall_cnt(stall_cnt)
  );

  // narrow-counter instance so saturation is reachable in a short run
  pipeline_sched #(.CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .ir_rd(ir_rd), .ir_ex(ir_ex), .ir_wb(ir_wb),
    .br_cond(br_cond), .pc_inc(s_pc_inc), .pc_br(s_pc_br), .ir1_load(s_ir1_load),
    .ir2_load(s_ir2_load), .ir3_load(s_ir3_load), .en_rd(s_en_rd), .en_ex(s_en_ex),
    .en_wb(s_en_wb), .stall(s_stall), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  always #5 clock = ~clock;

  // datapath model: PC, IR1..IR3 driven by the scheduler strobes
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pc    <= 6'd0;
      ir_rd <= 8'h0A;
      ir_ex <= 8'h0A;
      ir_wb <= 8'h0A;
    end else begin
      if (pc_br)       pc <= 6'd32;
      else if (pc_inc) pc <= pc + 6'd1;
      if (ir1_load) ir_rd <= imem[pc];
      if (ir2_load) ir_ex <= ir_rd;
      if (ir3_load) ir_wb <= ir_ex;
    end
  end

  task automatic fill_imem(input logic [7:0] v);
    for (int i = 0; i < 64; i++) imem[i] = v;
  endtask

  task automatic restart();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (obs !== 10'b0 || stall_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_hold: strobes=%b cnt=%0d expected 0/0", obs, stall_cnt);
    end
    fill_imem(8'h0A);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_nop_stream();
    logic [9:0] exp_v [0:5];
    exp_v = '{ADV0, ADV_R, ADV_RE, ADV_ALL, ADV_ALL, ADV_ALL};
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== exp_v[c] || stall_cnt !== 16'd0) begin
        n_errors++;
        $display("FAIL nop_stream c%0d: strobes=%b cnt=%0d expected %b cnt=0", c, obs, stall_cnt, exp_v[c]);
      end
    end
  endtask

  task automatic test_raw_hazard();
    logic [9:0]  exp_v [0:6];
    logic [15:0] exp_c [0:6];
    exp_v = '{ADV0, ADV_R, STALL_EX, STALL_WB, ADV_R, ADV_RE, ADV_ALL};
    exp_c = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd2, 16'd2};
    fill_imem(8'h0A);
    imem[0] = 8'h64;
    imem[1] = 8'h16;
    restart();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== exp_v[c] || stall_cnt !== exp_c[c]) begin
        n_errors++;
        $display("FAIL raw_hazard c%0d: strobes=%b cnt=%0d expected %b cnt=%0d", c, obs, stall_cnt, exp_v[c], exp_c[c]);
      end
    end
    n_checks++;
    if (ir_wb !== 8'h16) begin
      n_errors++;
      $display("FAIL raw_retire: ir_wb=%h expected 16", ir_wb);
    end
  endtask

  task automatic test_ori_hazard();
    logic [9:0]  exp_v [0:6];
    logic [9:0]  exp_n [0:6];
    logic [15:0] exp_c;
    exp_v = '{ADV0, ADV_R, STALL_EX, STALL_WB, ADV_R, ADV_RE, ADV_ALL};
    exp_n = '{ADV0, ADV_R, ADV_RE, ADV_ALL, ADV_ALL, ADV_ALL, ADV_ALL};
    for (int p = 0; p < 2; p++) begin
      fill_imem(8'h0A);
      imem[0] = 8'hFF;
      imem[1] = (p == 0) ? 8'h64 : 8'h24;
      exp_c   = (p == 0) ? 16'd2 : 16'd0;
      restart();
      for (int c = 0; c < 7; c++) begin
        if (c > 0) step();
        n_checks++;
        if (obs !== ((p == 0) ? exp_v[c] : exp_n[c])) begin
          n_errors++;
          $display("FAIL ori_hazard p%0d c%0d: strobes=%b expected %b", p, c, obs,
                   (p == 0) ? exp_v[c] : exp_n[c]);
        end
      end
      n_checks++;
      if (stall_cnt !== exp_c) begin
        n_errors++;
        $display("FAIL ori_count p%0d: cnt=%0d expected %0d", p, stall_cnt, exp_c);
      end
    end
  endtask

  task automatic test_branch();
    logic [9:0] exp_t [0:6];
    logic [9:0] exp_f [0:6];
    logic [7:0] exp_wb [3:5];
    exp_t  = '{ADV0, ADV_R, TAKEN, POST_BR, ADV_R, ADV_RE, ADV_ALL};
    exp_f  = '{ADV0, ADV_R, ADV_RE, ADV_ALL, ADV_ALL, ADV_ALL, ADV_ALL};
    exp_wb = '{8'h25, 8'h64, 8'h24};
    for (int p = 0; p < 2; p++) begin
      fill_imem(8'h0A);
      imem[0] = 8'h25;
      imem[1] = 8'h64;
      imem[2] = 8'h24;
      br_cond = (p == 0);
      restart();
      for (int c = 0; c < 7; c++) begin
        if (c > 0) step();
        n_checks++;
        if (obs !== ((p == 0) ? exp_t[c] : exp_f[c])) begin
          n_errors++;
          $display("FAIL branch p%0d c%0d: strobes=%b expected %b", p, c, obs,
                   (p == 0) ? exp_t[c] : exp_f[c]);
        end
        if (p == 1 && c >= 3 && c <= 5) begin
          n_checks++;
          if (ir_wb !== exp_wb[c]) begin
            n_errors++;
            $display("FAIL branch_order c%0d: ir_wb=%h expected %h", c, ir_wb, exp_wb[c]);
          end
        end
      end
    end
    br_cond = 1'b0;
  endtask

  task automatic test_stop();
    logic [9:0] exp_v [0:8];
    exp_v = '{ADV0, ADV_R, STOP_EX, STOP_WB, HALT, HALT, HALT, HALT, HALT};
    fill_imem(8'h64);
    imem[0] = 8'h01;
    restart();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== exp_v[c] || stall_cnt !== 16'd0) begin
        n_errors++;
        $display("FAIL stop c%0d: strobes=%b cnt=%0d expected %b cnt=0", c, obs, stall_cnt, exp_v[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // halted pipeline left by test_stop
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b0 || stall_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_halted: strobes=%b cnt=%0d expected 0/0", obs, stall_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== ADV0) begin
      n_errors++;
      $display("FAIL reset_halted_c0: strobes=%b expected %b", obs, ADV0);
    end
    step();
    n_checks++;
    if (obs !== ADV_R) begin
      n_errors++;
      $display("FAIL reset_halted_c1: strobes=%b expected %b", obs, ADV_R);
    end
    // reset during the second cycle of a RAW stall
    fill_imem(8'h0A);
    imem[0] = 8'h64;
    imem[1] = 8'h16;
    restart();
    for (int c = 1; c <= 3; c++) step();
    n_checks++;
    if (obs !== STALL_WB || stall_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL pre_reset_stall: strobes=%b cnt=%0d expected %b cnt=1", obs, stall_cnt, STALL_WB);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b0 || stall_cnt !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_stall: strobes=%b cnt=%0d expected 0/0", obs, stall_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      n_checks++;
      if (obs !== ((c == 0) ? ADV0 : (c == 1) ? ADV_R : STALL_EX) || stall_cnt !== 16'd0) begin
        n_errors++;
        $display("FAIL reset_resume c%0d: strobes=%b cnt=%0d", c, obs, stall_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    // chain of add R1,R1 gives stalls on cycles 2,3,5,6,8,9,...
    fill_imem(8'h54);
    restart();
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 10 || c == 24 || c == 25 || c == 40) begin
        n_checks++;
        case (c)
          10: if (stall_cnt !== 16'd6 || s_stall_cnt !== 4'd6) begin
                n_errors++;
                $display("FAIL sat c10: cnt=%0d narrow=%0d expected 6/6", stall_cnt, s_stall_cnt);
              end
          24: if (stall_cnt !== 16'd15 || s_stall_cnt !== 4'hF) begin
                n_errors++;
                $display("FAIL sat c24: cnt=%0d narrow=%0d expected 15/15", stall_cnt, s_stall_cnt);
              end
          25: if (stall_cnt !== 16'd16 || s_stall_cnt !== 4'hF) begin
                n_errors++;
                $display("FAIL sat c25: cnt=%0d narrow=%0d expected 16/15", stall_cnt, s_stall_cnt);
              end
          default: if (stall_cnt !== 16'd26 || s_stall_cnt !== 4'hF) begin
                n_errors++;
                $display("FAIL sat c40: cnt=%0d narrow=%0d expected 26/15", stall_cnt, s_stall_cnt);
              end
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_raw_hazard();
    test_ori_hazard();
    test_branch();
    test_stop();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
